temp_buf_reader: RTL and testbench

Reads a burst of accumulator words back out of the single-port temp buffer RAM that the layer write-back path fills, and re-packs them into one wide vector for the next MNIST layer stage. It issues sequential read addresses, absorbs a fixed RAM read latency, and presents the packed vector through a valid/ready handshake. The block sits between the temp buffer RAM read port and the next layer's input staging.

---
 rtl/temp_buf_pkg.sv | 22 ++
 rtl/temp_buf_rd_lat_pipe.sv | 31 +++
 rtl/temp_buf_reader.sv | 104 ++++++++++
 tb/tb_temp_buf_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_buf_pkg.sv
// Constants, FSM state type and slot packing helper shared by the temp buffer
// write-back and read-back paths.
`timescale 1ns/1ps
package temp_buf_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned NUM_WORDS  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } rd_state_e;

  // Slot 0 (first word of a burst) occupies the most significant word.
  function automatic int unsigned slot_lsb(input int unsigned slot);
    return (NUM_WORDS - 1 - slot) * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/temp_buf_rd_lat_pipe.sv
// RD_LATENCY-deep valid shift register; delays the issue tag so it lines up
// with the RAM read data it belongs to.
`timescale 1ns/1ps
module temp_buf_rd_lat_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_tag,
  output logic capture_tag
);

  logic [RD_LATENCY-1:0] tag_q;

  generate
    if (RD_LATENCY == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= issue_tag;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= {tag_q[RD_LATENCY-2:0], issue_tag};
      end
    end
  endgenerate

  assign capture_tag = tag_q[RD_LATENCY-1];

endmodule

// File: rtl/temp_buf_reader.sv
// Reads a NUM_WORDS burst from the temp buffer RAM and packs it into one wide
// vector with a valid/ready handshake. Define TEMP_BUF_RD_RELU_EN to clamp
// negative words to zero at capture.
`timescale 1ns/1ps
module temp_buf_reader
  import temp_buf_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rd_start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            mem_en,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] data_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            rd_busy
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);

  rd_state_e             state;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      capture_cnt;
  logic                  capture_tag;
  logic [DATA_WIDTH-1:0] word_c;

  temp_buf_rd_lat_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_tag   (mem_en),
    .capture_tag (capture_tag)
  );

  always_comb begin
`ifdef TEMP_BUF_RD_RELU_EN
    word_c = mem_rdata[DATA_WIDTH-1] ? '0 : mem_rdata;
`else
    word_c = mem_rdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      issue_cnt   <= '0;
      capture_cnt <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      rd_busy     <= 1'b0;
    end else begin
      if (capture_tag) begin
        data_out[slot_lsb(32'(capture_cnt)) +: DATA_WIDTH] <= word_c;
        capture_cnt <= capture_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (rd_start) begin
            state       <= ISSUE;
            mem_en      <= 1'b1;
            mem_addr    <= base_addr;
            issue_cnt   <= '0;
            capture_cnt <= '0;
            rd_busy     <= 1'b1;
          end
        end
        ISSUE: begin
          mem_addr  <= mem_addr + ADDR_WIDTH'(1);
          issue_cnt <= issue_cnt + CNT_W'(1);
          if (issue_cnt == LAST_IDX) begin
            mem_en <= 1'b0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave in the same cycle the last word lands so out_valid is not delayed.
          if ((capture_tag && capture_cnt == LAST_IDX) || capture_cnt == FULL_CNT) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd_busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_buf_reader.sv
// Directed bench for temp_buf_reader; two instances cover RD_LATENCY 1 and 3.
`timescale 1ns/1ps
module tb_temp_buf_reader;
  import temp_buf_pkg::*;

  localparam int unsigned BW = DATA_WIDTH * NUM_WORDS;

  typedef struct {
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  v1;
    logic                  b1;
    logic                  v3;
    logic                  b3;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rd_start;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  mem_en1, mem_en3;
  logic [ADDR_WIDTH-1:0] mem_addr1, mem_addr3;
  logic [DATA_WIDTH-1:0] rdata1, rdata3;
  logic [BW-1:0]         dout1, dout3;
  logic                  valid1, valid3, busy1, busy3;

  logic [DATA_WIDTH-1:0] mem [128];
  logic [DATA_WIDTH-1:0] rq3 [3];
  vec_t                  tbl [16];
  int                    total = 0;
  int                    bad = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rdata1 <= mem_en1 ? mem[mem_addr1] : 32'hDEAD_BEEF;

  always_ff @(posedge clk) begin
    rq3[0] <= mem_en3 ? mem[mem_addr3] : 32'hDEAD_BEEF;
    rq3[1] <= rq3[0];
    rq3[2] <= rq3[1];
  end
  assign rdata3 = rq3[2];

  temp_buf_reader #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .base_addr(base_addr),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(rdata1),
    .data_out(dout1), .out_valid(valid1), .out_ready(out_ready), .rd_busy(busy1)
  );

  temp_buf_reader #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .rd_start(rd_start), .base_addr(base_addr),
    .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_rdata(rdata3),
    .data_out(dout3), .out_valid(valid3), .out_ready(out_ready), .rd_busy(busy3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_WIDTH-1:0] exp_word(input logic [ADDR_WIDTH-1:0] base, input int k);
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] w;
    a = base + ADDR_WIDTH'(k);
    w = mem[a];
`ifdef TEMP_BUF_RD_RELU_EN
    if (w[DATA_WIDTH-1]) w = '0;
`endif
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] slot_of(input logic [BW-1:0] v, input int k);
    return v[(NUM_WORDS-k)*DATA_WIDTH-1 -: DATA_WIDTH];
  endfunction

  task automatic check_data(input string tag, input logic [ADDR_WIDTH-1:0] base);
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      chk($sformatf("%s_l1_slot%0d", tag, k), 64'(slot_of(dout1, k)), 64'(exp_word(base, k)));
      chk($sformatf("%s_l3_slot%0d", tag, k), 64'(slot_of(dout3, k)), 64'(exp_word(base, k)));
    end
  endtask

  // Full burst with out_ready high; tracks issued addresses and out_valid rise.
  task automatic burst(input logic [ADDR_WIDTH-1:0] base, input string tag);
    int n1, n3, vc1, vc3, c;
    base_addr = base;
    out_ready = 1'b1;
    rd_start  = 1'b1;
    n1 = 0; n3 = 0; vc1 = -1; vc3 = -1; c = 0;
    do begin
      step();
      c++;
      rd_start = 1'b0;
      if (mem_en1) begin
        chk($sformatf("%s_addr1_%0d", tag, n1), 64'(mem_addr1), 64'(ADDR_WIDTH'(base + ADDR_WIDTH'(n1))));
        n1++;
      end
      if (mem_en3) begin
        chk($sformatf("%s_addr3_%0d", tag, n3), 64'(mem_addr3), 64'(ADDR_WIDTH'(base + ADDR_WIDTH'(n3))));
        n3++;
      end
      if (valid1 && vc1 < 0) vc1 = c;
      if (valid3 && vc3 < 0) vc3 = c;
    end while ((busy1 || busy3) && c < 40);
    chk({tag, "_timeout"}, 64'(c < 40), 64'd1);
    chk({tag, "_n1"}, 64'(n1), 64'd10);
    chk({tag, "_n3"}, 64'(n3), 64'd10);
    chk({tag, "_vcyc1"}, 64'(vc1), 64'd12);
    chk({tag, "_vcyc3"}, 64'(vc3), 64'd14);
    check_data(tag, base);
  endtask

  initial begin
    int c;
    for (int a = 0; a < 128; a++) mem[a] = DATA_WIDTH'(a + 1);
    mem[60] = 32'hFFFF_FFF0;
    mem[61] = 32'h0000_0010;

    for (int i = 0; i < 16; i++) begin
      tbl[i].en   = (i >= 1 && i <= 10);
      tbl[i].addr = ADDR_WIDTH'(i - 1);
      tbl[i].v1   = (i == 12);
      tbl[i].b1   = (i >= 1 && i <= 12);
      tbl[i].v3   = (i == 14);
      tbl[i].b3   = (i >= 1 && i <= 14);
    end

    rst = 1'b1; rd_start = 1'b0; out_ready = 1'b1; base_addr = '0;
    step(); step(); step();
    chk("rst_en", 64'(mem_en1), 64'd0);
    chk("rst_addr", 64'(mem_addr1), 64'd0);
    chk("rst_valid", 64'(valid1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_dout", 64'(dout1 == '0), 64'd1);
    chk("rst_dout3", 64'(dout3 == '0), 64'd1);
    rst = 1'b0;
    step();

    // Basic burst, cycle by cycle against the table
    base_addr = '0;
    rd_start  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        step();
        rd_start = 1'b0;
      end
      chk($sformatf("tbl_en1_c%0d", i), 64'(mem_en1), 64'(tbl[i].en));
      chk($sformatf("tbl_en3_c%0d", i), 64'(mem_en3), 64'(tbl[i].en));
      if (tbl[i].en) begin
        chk($sformatf("tbl_addr1_c%0d", i), 64'(mem_addr1), 64'(tbl[i].addr));
        chk($sformatf("tbl_addr3_c%0d", i), 64'(mem_addr3), 64'(tbl[i].addr));
      end
      chk($sformatf("tbl_v1_c%0d", i), 64'(valid1), 64'(tbl[i].v1));
      chk($sformatf("tbl_b1_c%0d", i), 64'(busy1), 64'(tbl[i].b1));
      chk($sformatf("tbl_v3_c%0d", i), 64'(valid3), 64'(tbl[i].v3));
      chk($sformatf("tbl_b3_c%0d", i), 64'(busy3), 64'(tbl[i].b3));
    end
    chk("basic_msw", 64'(dout1[319:288]), 64'd1);
    chk("basic_lsw", 64'(dout1[31:0]), 64'd10);
    chk("basic_msw3", 64'(dout3[319:288]), 64'd1);
    chk("basic_lsw3", 64'(dout3[31:0]), 64'd10);
    check_data("basic", '0);
    step();

    // Address wrap at 127 -> 0
    burst(7'd124, "wrap");
    chk("wrap_slot3", 64'(slot_of(dout1, 3)), 64'd128);
    chk("wrap_slot4", 64'(slot_of(dout1, 4)), 64'd1);
    step();

    // Backpressure with an ignored rd_start during HOLD
    out_ready = 1'b0;
    base_addr = 7'd20;
    rd_start  = 1'b1;
    c = 0;
    do begin
      step();
      rd_start = 1'b0;
      c++;
    end while (!valid1 && c < 30);
    chk("bp_valid_seen", 64'(valid1), 64'd1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("bp_valid_%0d", i), 64'(valid1), 64'd1);
      chk($sformatf("bp_en1_%0d", i), 64'(mem_en1), 64'd0);
      chk($sformatf("bp_w0_%0d", i), 64'(slot_of(dout1, 0)), 64'(exp_word(7'd20, 0)));
      chk($sformatf("bp_w9_%0d", i), 64'(slot_of(dout1, 9)), 64'(exp_word(7'd20, 9)));
      rd_start = (i == 5);
      step();
    end
    rd_start = 1'b0;
    chk("bp_valid3", 64'(valid3), 64'd1);
    out_ready = 1'b1;
    rd_start  = 1'b1;
    step();
    rd_start = 1'b0;
    chk("bp_after_valid", 64'(valid1), 64'd0);
    chk("bp_after_busy", 64'(busy1), 64'd0);
    chk("bp_after_valid3", 64'(valid3), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_idle_en_%0d", i), 64'(mem_en1), 64'd0);
      chk($sformatf("bp_idle_busy_%0d", i), 64'(busy1), 64'd0);
      chk($sformatf("bp_idle_busy3_%0d", i), 64'(busy3), 64'd0);
    end
    check_data("bp", 7'd20);

    // Reset in cycle 5 of a burst
    base_addr = 7'd40;
    rd_start  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      rd_start = 1'b0;
    end
    chk("mid_en_before", 64'(mem_en1), 64'd1);
    rst = 1'b1;
    step();
    chk("mid_en", 64'(mem_en1), 64'd0);
    chk("mid_addr", 64'(mem_addr1), 64'd0);
    chk("mid_valid", 64'(valid1), 64'd0);
    chk("mid_busy", 64'(busy1), 64'd0);
    chk("mid_dout", 64'(dout1 == '0), 64'd1);
    chk("mid_dout3", 64'(dout3 == '0), 64'd1);
    rst = 1'b0;
    step();
    burst(7'd40, "post_rst");
    step();

    // Negative and positive words, with and without clamping
    burst(7'd60, "relu");
`ifdef TEMP_BUF_RD_RELU_EN
    chk("relu_neg", 64'(slot_of(dout1, 0)), 64'd0);
`else
    chk("relu_neg", 64'(slot_of(dout1, 0)), 64'hFFFF_FFF0);
`endif
    chk("relu_pos", 64'(slot_of(dout1, 1)), 64'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
